// File: rtl/pipe_reg_hs.sv
// pipe_reg_hs: falling-edge valid/ready pipeline register with bubble-on-empty control.
// Define PIPE_REG_HS_SKID_EN for a two-entry skid build with a registered in_ready.
module pipe_reg_hs #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   input  logic              flush,
   output logic [1:0]        occupancy
);
   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
   state_t            state;
   logic [DATA_W-1:0] head_data;
   logic [CTRL_W-1:0] head_ctrl;
   logic              accept;
   logic              consume;
   assign out_valid = state != EMPTY;
   assign out_data  = head_data;
   assign out_ctrl  = out_valid ? head_ctrl : '0;
   assign occupancy = state;
   assign accept    = in_valid && in_ready;
   assign consume   = out_valid && out_ready;
`ifdef PIPE_REG_HS_SKID_EN
   logic [DATA_W-1:0] skid_data;
   logic [CTRL_W-1:0] skid_ctrl;
   logic              ready_q;
   assign in_ready = ready_q;
   // ready_q tracks (state != TWO) so upstream never sees out_ready combinationally
   always_ff @(negedge clk or negedge reset)
      if (!reset) begin
         state     <= EMPTY;
         head_data <= '0;
         head_ctrl <= '0;
         skid_data <= '0;
         skid_ctrl <= '0;
         ready_q   <= 1'b1;
      end else if (flush) begin
         state   <= EMPTY;
         ready_q <= 1'b1;
      end else
         case (state)
            EMPTY: if (accept) begin
               head_data <= in_data;
               head_ctrl <= in_ctrl;
               state     <= ONE;
            end
            ONE: if (accept && consume) begin
               head_data <= in_data;
               head_ctrl <= in_ctrl;
            end else if (accept) begin
               skid_data <= in_data;
               skid_ctrl <= in_ctrl;
               state     <= TWO;
               ready_q   <= 1'b0;
            end else if (consume)
               state <= EMPTY;
            TWO: if (consume) begin
               head_data <= skid_data;
               head_ctrl <= skid_ctrl;
               state     <= ONE;
               ready_q   <= 1'b1;
            end
            default: begin
               state   <= EMPTY;
               ready_q <= 1'b1;
            end
         endcase
`else
   assign in_ready = !out_valid || out_ready;
   always_ff @(negedge clk or negedge reset)
      if (!reset) begin
         state     <= EMPTY;
         head_data <= '0;
         head_ctrl <= '0;
      end else if (flush)
         state <= EMPTY;
      else
         case (state)
            EMPTY: if (accept) begin
               head_data <= in_data;
               head_ctrl <= in_ctrl;
               state     <= ONE;
            end
            ONE: if (accept) begin
               head_data <= in_data;
               head_ctrl <= in_ctrl;
            end else if (consume)
               state <= EMPTY;
            default: state <= EMPTY;
         endcase
`endif
endmodule

// File: doc/pipe_reg_hs.md
PIPE_REG_HS -- requirements
Module: pipe_reg_hs

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the width of the datapath payload (pc, register data, offset, fields).
REQ-002 Parameter CTRL_W, default 10, SHALL set the width of the control payload (alusrc, regdst, regwrite, aluop[3:0], memwrite, memread, memtoreg).
REQ-003 clk  in  1  SHALL be the single clock; all state SHALL update on the falling edge, per pipeline-register practice.
REQ-004 reset  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 in_valid  in  1  SHALL mark upstream payload valid.
REQ-006 in_ready  out  1  SHALL mark that the stage accepts payload this edge.
REQ-007 in_data  in  DATA_W  SHALL be the upstream datapath payload.
REQ-008 in_ctrl  in  CTRL_W  SHALL be the upstream control payload.
REQ-009 out_valid  out  1  SHALL mark downstream payload valid.
REQ-010 out_ready  in  1  SHALL mark that downstream consumes payload this edge.
REQ-011 out_data  out  DATA_W  SHALL be the head-entry datapath payload.
REQ-012 out_ctrl  out  CTRL_W  SHALL be the head-entry control payload.
REQ-013 flush  in  1  SHALL discard all held entries (branch/hazard bubble).
REQ-014 occupancy  out  2  SHALL report held entries (0..2).

Function
REQ-015 Accept SHALL occur on a falling edge where in_valid=1 and in_ready=1; consume SHALL occur where out_valid=1 and out_ready=1.
REQ-016 Entries SHALL leave in strict arrival order; no entry SHALL be duplicated or lost except by flush or reset.
REQ-017 Latency SHALL be one falling edge: payload accepted into an empty stage appears on out_* immediately after that edge.
REQ-018 States SHALL be EMPTY (occ 0), ONE (occ 1), TWO (occ 2, skid build only).
REQ-019 EMPTY: accept -> ONE; otherwise stay.
REQ-020 ONE: accept and consume -> ONE with new head; accept only -> TWO (skid build) ; consume only -> EMPTY; neither -> hold.
REQ-021 TWO: consume -> ONE with skid entry promoted to head; no accept SHALL occur in TWO.
REQ-022 out_valid SHALL equal (occupancy != 0); out_ctrl SHALL be forced to all-zero whenever out_valid=0 so an empty stage presents a bubble.
REQ-023 out_data SHALL hold its last value when out_valid=0.
REQ-024 flush SHALL take precedence over simultaneous accept and consume: next state EMPTY, occupancy 0, in_ready 1.
REQ-025 Payload SHALL be held bit-exact while out_valid=1 and out_ready=0.

Reset
REQ-026 reset low SHALL immediately set state EMPTY, occupancy 0, out_valid 0, out_data 0, out_ctrl 0, skid storage 0, in_ready 1 (skid build) / in_ready 1 (bypass build, as stage empty).
REQ-027 Reset asserted mid-transfer SHALL drop all entries; first accept after release SHALL follow EMPTY rules.

Configuration
REQ-028 Macro PIPE_REG_HS_SKID_EN defined SHALL compile a second (skid) entry; in_ready SHALL then be a register equal to (state != TWO), with no combinational path from out_ready.
REQ-029 PIPE_REG_HS_SKID_EN undefined SHALL compile one entry only; in_ready SHALL equal (!out_valid || out_ready) combinationally; state TWO and occupancy 2 SHALL never occur.

Verification
REQ-030 Reset low with in_valid=1, in_data=32'hDEADBEEF -> out_valid 0, out_ctrl 0, out_data 0, occupancy 0 throughout.
REQ-031 Stream 8 words 1..8, out_ready=1 constantly -> out_data 1..8 in order, one per edge, latency 1 edge, occupancy never exceeds 1.
REQ-032 Skid build: ONE state holding 5, out_ready=0, accept 6 -> occupancy 2, in_ready 0 next edge; out_ready=1 -> out 5 then 6, in_ready returns 1.
REQ-033 Bypass build: out_valid=1, out_ready=0 -> in_ready 0 same cycle; out_ready=1 -> in_ready 1 same cycle with no registered delay.
REQ-034 Occupancy 2, flush=1 with in_valid=1, out_ready=1 -> next edge occupancy 0, out_valid 0, out_ctrl 10'h000, flushed and offered words never appear.
REQ-035 in_ctrl=10'h3FF held 3 edges under out_ready=0 -> out_ctrl stays 10'h3FF; after consume with no new input -> out_ctrl 10'h000.
